// File: rtl/bloonstd1_soc_pulse_pio.sv
// bloonstd1_soc_pulse_pio: Avalon-MM parallel output port with SET/CLEAR
// registers and optional self-clearing pulse timer.
// Optional feature macro: PULSE_PIO_PULSE_EN (enables PULSE_LEN, PULSE,
// pulse mask and down-counter; without it addresses 3/4 read 0).
module bloonstd1_soc_pulse_pio #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      CNT_W       = 16,
    parameter int unsigned      DEFAULT_LEN = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    typedef enum logic [2:0] {
        ADDR_DATA   = 3'd0,
        ADDR_SET    = 3'd1,
        ADDR_CLEAR  = 3'd2,
        ADDR_LEN    = 3'd3,
        ADDR_PULSE  = 3'd4,
        ADDR_RSVD5  = 3'd5,
        ADDR_RSVD6  = 3'd6,
        ADDR_RSVD7  = 3'd7
    } reg_addr_e;

    reg_addr_e        addr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             unused_wdata;

    assign addr         = reg_addr_e'(address);
    assign wr_en        = chipselect && !write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    assign out_port     = data_q;
    assign unused_wdata = ^writedata;

`ifdef PULSE_PIO_PULSE_EN

    localparam logic [CNT_W-1:0] LEN_RST = CNT_W'(DEFAULT_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_d;
    logic             busy_q;
    logic             busy_d;

    // Next state: timer expiry/decrement is resolved first, then the CPU
    // write is layered on top so a colliding write wins on its bits.
    always_comb begin
        data_d = data_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        len_d  = len_q;

        if (busy_q) begin
            if (cnt_q == CNT_ONE) begin
                data_d = data_q & ~mask_q;
                mask_d = '0;
                cnt_d  = '0;
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        if (wr_en) begin
            case (addr)
                ADDR_DATA: begin
                    data_d = wr_bits;
                    mask_d = '0;
                end
                ADDR_SET: begin
                    data_d = data_d | wr_bits;
                end
                ADDR_CLEAR: begin
                    data_d = data_d & ~wr_bits;
                    mask_d = mask_d & ~wr_bits;
                end
                ADDR_LEN: begin
                    len_d = writedata[CNT_W-1:0];
                end
                ADDR_PULSE: begin
                    if ((len_q != '0) && (wr_bits != '0)) begin
                        data_d = data_d | wr_bits;
                        mask_d = mask_d | wr_bits;
                        cnt_d  = len_q;
                        busy_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase

            // A pulse with no bits left to clear is finished.
            if (((addr == ADDR_DATA) || (addr == ADDR_CLEAR)) && (mask_d == '0)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            mask_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            len_q  <= LEN_RST;
        end else begin
            data_q <= data_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            len_q  <= len_d;
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        readdata = '0;
        case (addr)
            ADDR_DATA: begin
                readdata[WIDTH-1:0] = data_q;
            end
            ADDR_LEN: begin
                readdata[CNT_W-1:0] = len_q;
            end
            ADDR_PULSE: begin
                readdata[31]        = busy_q;
                readdata[CNT_W-1:0] = cnt_q;
            end
            default: begin
            end
        endcase
    end

`else

    logic [CNT_W-1:0] unused_len;
    assign unused_len = CNT_W'(DEFAULT_LEN);

    // Next state for the plain data register; pulse addresses are inert.
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (addr)
                ADDR_DATA:  data_d = wr_bits;
                ADDR_SET:   data_d = data_q | wr_bits;
                ADDR_CLEAR: data_d = data_q & ~wr_bits;
                default: begin
                end
            endcase
        end
    end

    // Data register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        readdata = '0;
        if (addr == ADDR_DATA) begin
            readdata[WIDTH-1:0] = data_q;
        end
    end

`endif

endmodule

// File: tb/tb_bloonstd1_soc_pulse_pio.sv
// Self-checking bench for bloonstd1_soc_pulse_pio (WIDTH=8): table vectors,
// directed pulse corner cases and a randomized phase against a
// timestamp-based reference model.
module tb_bloonstd1_soc_pulse_pio;

    localparam int unsigned      WIDTH    = 8;
    localparam logic [WIDTH-1:0] RST_VAL  = 8'h5A;
    localparam int unsigned      CNT_W    = 16;
    localparam int unsigned      DEF_LEN  = 16;
`ifdef PULSE_PIO_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bloonstd1_soc_pulse_pio #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RST_VAL),
        .CNT_W       (CNT_W),
        .DEFAULT_LEN (DEF_LEN)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: pulse tracked as an absolute expiry edge number.
    bit [7:0]    m_data;
    bit [7:0]    m_mask;
    bit          m_act;
    int unsigned m_len;
    int unsigned m_exp;
    int unsigned now = 0;

    task automatic model_edge(input bit rst_n_i, input bit wr, input bit [2:0] a,
                              input bit [31:0] wd);
        bit [7:0] b;
        b = wd[7:0];
        now++;
        if (!rst_n_i) begin
            m_data = RST_VAL;
            m_mask = '0;
            m_act  = 1'b0;
            m_len  = DEF_LEN;
            return;
        end
        if (m_act && now == m_exp) begin
            m_data = m_data & ~m_mask;
            m_mask = '0;
            m_act  = 1'b0;
        end
        if (wr) begin
            case (a)
                3'd0: begin m_data = b; m_mask = '0; end
                3'd1: m_data = m_data | b;
                3'd2: begin m_data = m_data & ~b; m_mask = m_mask & ~b; end
                3'd3: if (PULSE_EN) m_len = int'(wd[15:0]);
                3'd4: if (PULSE_EN && m_len != 0 && b != 0) begin
                    m_data = m_data | b;
                    m_mask = m_mask | b;
                    m_act  = 1'b1;
                    m_exp  = now + m_len;
                end
                default: ;
            endcase
        end
        if (m_mask == 0) m_act = 1'b0;
    endtask

    function automatic bit [31:0] model_rd(input bit [2:0] a);
        bit [15:0] c;
        case (a)
            3'd0: return {24'd0, m_data};
            3'd3: return PULSE_EN ? {16'd0, 16'(m_len)} : 32'd0;
            3'd4: begin
                if (!PULSE_EN || !m_act) return 32'd0;
                c = 16'(m_exp - now);
                return {1'b1, 15'd0, c};
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock edge with the given bus/reset inputs; model follows.
    task automatic step(input bit rst_n_i, input bit cs, input bit wn, input bit [2:0] a,
                        input bit [31:0] wd);
        @(negedge clk);
        reset_n    = rst_n_i;
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        model_edge(rst_n_i, cs && !wn, a, wd);
        #1;
        reset_n    = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input bit [2:0] a, input bit [31:0] wd);
        step(1'b1, 1'b1, 1'b0, a, wd);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    task automatic expect_state(input string name, input bit [2:0] ra,
                                input bit [7:0] exp_out, input bit [31:0] exp_rd);
        address = ra;
        #1;
        check({name, "_out"}, {24'd0, out_port}, {24'd0, exp_out});
        check({name, "_rd"}, readdata, exp_rd);
    endtask

    typedef struct {
        bit        cs;
        bit        wn;
        bit [2:0]  addr;
        bit [31:0] wd;
        bit [2:0]  raddr;
        bit [7:0]  exp_out;
        bit [31:0] exp_rd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h0000_00A5, 3'd0, 8'hA5, 32'h0000_00A5};
        vecs[1]  = '{1'b1, 1'b0, 3'd0, 32'h0000_000F, 3'd0, 8'h0F, 32'h0000_000F};
        vecs[2]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0030, 3'd0, 8'h3F, 32'h0000_003F};
        vecs[3]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0003, 3'd0, 8'h3C, 32'h0000_003C};
        vecs[4]  = '{1'b1, 1'b1, 3'd0, 32'h0000_00FF, 3'd0, 8'h3C, 32'h0000_003C};
        vecs[5]  = '{1'b0, 1'b0, 3'd0, 32'h0000_00FF, 3'd0, 8'h3C, 32'h0000_003C};
        vecs[6]  = '{1'b1, 1'b0, 3'd5, 32'h0000_00FF, 3'd5, 8'h3C, 32'h0000_0000};
        vecs[7]  = '{1'b1, 1'b0, 3'd0, 32'h1234_5681, 3'd0, 8'h81, 32'h0000_0081};
        vecs[8]  = '{1'b1, 1'b0, 3'd2, 32'hFFFF_FF01, 3'd7, 8'h80, 32'h0000_0000};
        vecs[9]  = '{1'b1, 1'b0, 3'd1, 32'hFFFF_0000, 3'd0, 8'h80, 32'h0000_0080};
        vecs[10] = '{1'b1, 1'b0, 3'd6, 32'h0000_0000, 3'd6, 8'h80, 32'h0000_0000};
        vecs[11] = '{1'b0, 1'b1, 3'd0, 32'h0000_0000, 3'd1, 8'h80, 32'h0000_0000};
        vecs[12] = '{1'b0, 1'b1, 3'd0, 32'h0000_0000, 3'd2, 8'h80, 32'h0000_0000};

        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 3'd0;
        writedata  = 32'd0;

        step(1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 3'd0, 32'd0);
        expect_state("reset_data", 3'd0, 8'h5A, 32'h0000_005A);
        expect_state("reset_len", 3'd3, 8'h5A, PULSE_EN ? 32'd16 : 32'd0);
        expect_state("reset_status", 3'd4, 8'h5A, 32'd0);

        for (int i = 0; i < 13; i++) begin
            step(1'b1, vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd);
            expect_state($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp_out, vecs[i].exp_rd);
        end

`ifdef PULSE_PIO_PULSE_EN
        // Pulse timing: N=5, bit0 high for exactly 5 cycles.
        wr(3'd0, 32'd0);
        wr(3'd3, 32'd5);
        expect_state("len5", 3'd3, 8'h00, 32'd5);
        wr(3'd4, 32'h01);
        expect_state("pulse_c1", 3'd4, 8'h01, 32'h8000_0005);
        for (int i = 2; i <= 5; i++) begin
            idle();
            expect_state($sformatf("pulse_c%0d", i), 3'd4, 8'h01, 32'h8000_0000 | (6 - i));
        end
        idle();
        expect_state("pulse_expired", 3'd4, 8'h00, 32'd0);

        // Retrigger: second pulse reloads counter, masks merge.
        wr(3'd3, 32'd4);
        wr(3'd4, 32'h01);
        idle();
        wr(3'd4, 32'h02);
        expect_state("retrig_c1", 3'd4, 8'h03, 32'h8000_0004);
        idle();
        idle();
        idle();
        expect_state("retrig_c4", 3'd4, 8'h03, 32'h8000_0001);
        idle();
        expect_state("retrig_exp", 3'd0, 8'h00, 32'd0);

        // Collision: SET in the expiry cycle wins on its bit.
        wr(3'd4, 32'h01);
        idle();
        idle();
        idle();
        wr(3'd1, 32'h01);
        expect_state("collide", 3'd4, 8'h01, 32'd0);
        idle();
        expect_state("collide_hold", 3'd0, 8'h01, 32'h01);

        // CLEAR removing every pulsed bit ends the pulse.
        wr(3'd0, 32'h00);
        wr(3'd4, 32'h0C);
        wr(3'd2, 32'h0C);
        expect_state("clr_mask", 3'd4, 8'h00, 32'd0);

        // Zero-bit pulse is ignored.
        wr(3'd4, 32'h100);
        expect_state("zero_bits", 3'd4, 8'h00, 32'd0);

        // Zero length: pulse ignored, output unchanged.
        wr(3'd0, 32'h42);
        wr(3'd3, 32'd0);
        wr(3'd4, 32'hFF);
        expect_state("zero_len", 3'd4, 8'h42, 32'd0);

        // Reset mid-pulse overrides a concurrent write.
        wr(3'd3, 32'd100);
        wr(3'd4, 32'h01);
        idle();
        step(1'b0, 1'b1, 1'b0, 3'd0, 32'hFF);
        expect_state("rst_mid_status", 3'd4, 8'h5A, 32'd0);
        expect_state("rst_mid_len", 3'd3, 8'h5A, 32'd16);
`else
        // Pulse registers absent: writes ignored, reads zero.
        wr(3'd3, 32'd5);
        expect_state("nolen", 3'd3, 8'h80, 32'd0);
        wr(3'd4, 32'hFF);
        expect_state("nopulse", 3'd4, 8'h80, 32'd0);
        step(1'b0, 1'b1, 1'b0, 3'd0, 32'hFF);
        expect_state("rst_override", 3'd0, 8'h5A, 32'h5A);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 500; i++) begin
            bit        r_rst;
            bit        r_cs;
            bit        r_wn;
            bit [2:0]  r_a;
            bit [31:0] r_wd;
            bit [2:0]  r_ra;
            r_rst = ($urandom_range(0, 99) >= 2);
            r_cs  = ($urandom_range(0, 2) != 0);
            r_wn  = ($urandom_range(0, 9) == 0);
            r_a   = 3'($urandom_range(0, 9) > 7 ? 4 : $urandom_range(0, 7));
            r_wd  = (r_a == 3'd3) ? 32'($urandom_range(0, 6)) : $urandom;
            r_ra  = 3'($urandom_range(0, 7));
            step(r_rst, r_cs, r_wn, r_a, r_wd);
            expect_state($sformatf("rand%0d", i), r_ra, m_data, model_rd(r_ra));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
